// File: rtl/rom_8x4.sv
// Registered 8x4 constant lookup table with one-cycle read latency.
// Optional even-parity output is built only when ROM_PARITY_EN is defined.
module rom_8x4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_en,
  input  logic [2:0] addr,
  output logic [3:0] data_out,
  output logic       data_valid
`ifdef ROM_PARITY_EN
  ,
  output logic       parity_out
`endif
);

  logic [3:0] rom_word;

  always_comb begin
    rom_word = '0;
    unique case (addr)
      3'd0: rom_word = 4'h3;
      3'd1: rom_word = 4'h7;
      3'd2: rom_word = 4'hA;
      3'd3: rom_word = 4'hF;
      3'd4: rom_word = 4'h1;
      3'd5: rom_word = 4'h8;
      3'd6: rom_word = 4'hC;
      3'd7: rom_word = 4'h5;
      default: rom_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_en;
      if (rd_en) begin
        data_out <= rom_word;
      end
    end
  end

`ifdef ROM_PARITY_EN
  // Parity is computed from the word being loaded so it stays aligned with data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_out <= 1'b0;
    end else if (rd_en) begin
      parity_out <= ^rom_word;
    end
  end
`endif

endmodule

// File: tb/tb_rom_8x4.sv
// Directed, table-driven bench for rom_8x4 plus reset corner sequences.
// Parity checks are compiled in only when ROM_PARITY_EN is defined.
module tb_rom_8x4;

  logic       clk;
  logic       rst_n;
  logic       rd_en;
  logic [2:0] addr;
  logic [3:0] data_out;
  logic       data_valid;
`ifdef ROM_PARITY_EN
  logic       parity_out;
`endif

  int unsigned n_total;
  int unsigned n_pass;

  typedef struct {
    logic       rd_en;
    logic [2:0] addr;
    logic [3:0] exp_data;
    logic       exp_valid;
    logic       exp_par;
  } vec_t;

  vec_t vecs[16];

  rom_8x4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_en      (rd_en),
    .addr       (addr),
    .data_out   (data_out),
    .data_valid (data_valid)
`ifdef ROM_PARITY_EN
    ,
    .parity_out (parity_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
    n_total++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_outputs(input string name, input logic [3:0] exp_data,
                               input logic exp_valid, input logic exp_par);
    check({name, ".data"}, data_out, exp_data);
    check({name, ".valid"}, {3'b000, data_valid}, {3'b000, exp_valid});
`ifdef ROM_PARITY_EN
    check({name, ".parity"}, {3'b000, parity_out}, {3'b000, exp_par});
`else
    if (exp_par === 1'bx) $display("unexpected X parity in table for %s", name);
`endif
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;

    // Sweep 0..7, then hold, then back-to-back reads of the same address.
    vecs[0]  = '{1'b1, 3'd0, 4'h3, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 3'd1, 4'h7, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 3'd2, 4'hA, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 3'd3, 4'hF, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 3'd4, 4'h1, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 3'd5, 4'h8, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 3'd6, 4'hC, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 3'd7, 4'h5, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 3'd2, 4'hA, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 3'd5, 4'hA, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'd3, 4'hA, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 3'd5, 4'h8, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 3'd5, 4'h8, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 3'd0, 4'h8, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 3'd1, 4'h7, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 3'd3, 4'hF, 1'b1, 1'b0};

    rst_n = 1'b0;
    rd_en = 1'b1;
    addr  = 3'd3;
    #2;
    check_outputs("reset_initial", 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("reset_held_through_edge", 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      rd_en = vecs[i].rd_en;
      addr  = vecs[i].addr;
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid, vecs[i].exp_par);
    end

    // Asynchronous assertion mid-cycle: outputs (0xF, valid) clear with no edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset_midcycle", 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Read of addr 3 in flight is discarded when reset lands before its result edge.
    rd_en = 1'b1;
    addr  = 3'd3;
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("midstream_reset_now", 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("midstream_reset_edge", 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    rd_en = 1'b1;
    addr  = 3'd6;
    @(posedge clk);
    #1;
    check_outputs("post_reset_read6", 4'hC, 1'b1, 1'b0);
    rd_en = 1'b0;
    addr  = 3'd1;
    @(posedge clk);
    #1;
    check_outputs("post_reset_hold", 4'hC, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
